// File: rtl/cp_bus_pkg.sv
// Shared constants and types for the host side of the shared-bus
// ALU coprocessor.
package cp_bus_pkg;

  localparam logic [3:0] OP_ADDI     = 4'd1;
  localparam logic [3:0] REQ_OPERAND = 4'b0011;
  localparam logic [3:0] REQ_VALUE   = 4'b0001;
  localparam logic [4:0] TIMEOUT     = 5'd31;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SERVE,
    S_RESULT
  } state_e;

  typedef logic [2:0] reg_idx_t;
  typedef logic [3:0] nib_t;

endpackage

// File: rtl/cp_regfile.sv
// 8x4 register file plus carry flag; two write ports, two
// combinational read ports.
module cp_regfile
  import cp_bus_pkg::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  logic     we0,
  input  reg_idx_t a0,
  input  nib_t     d0,
  input  logic     c0,
  input  logic     we1,
  input  reg_idx_t a1,
  input  nib_t     d1,
  input  reg_idx_t ra0,
  output nib_t     rd0,
  input  reg_idx_t ra1,
  output nib_t     rd1,
  output logic     carry
);

  nib_t regs [8];

  // Port 0 (writeback) wins when both ports hit one address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      carry <= 1'b0;
    end else begin
      if (we1 && !(we0 && a0 == a1)) regs[a1] <= d1;
      if (we0) begin
        regs[a0] <= d0;
        carry    <= c0;
      end
    end
  end

  assign rd0 = regs[ra0];
  assign rd1 = regs[ra1];

endmodule

// File: rtl/cp_bus_host.sv
// Host initiator: issues ADDI to the coprocessor, serves the operand
// on the shared bus, captures the result into the register file.
module cp_bus_host
  import cp_bus_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [3:0] cmd_imm,
  input  logic [2:0] cmd_rs,
  input  logic [2:0] cmd_rd,
  output logic       rsp_valid,
  output logic [3:0] rsp_data,
  output logic       rsp_carry,
  output logic       rsp_err,
  input  logic       wr_en,
  input  logic [2:0] wr_addr,
  input  logic [3:0] wr_data,
  input  logic [2:0] dbg_addr,
  output logic [3:0] dbg_data,
  output logic [3:0] cp_opcode,
  output logic [3:0] cp_imm,
  input  logic [3:0] cp_req,
  output logic [3:0] cp_bus_o,
  output logic       cp_bus_oe,
  input  logic [3:0] cp_bus_i,
  output logic       cp_oe_n,
  input  logic       cp_done,
  input  logic       cp_carry
);

  state_e   state_q, state_d;
  logic [4:0] wd_q;
  nib_t     imm_q, opnd_q, rs_data;
  reg_idx_t rd_q;
  logic     capture, abort;

  cp_regfile u_rf (
    .clk   (clk),
    .rst_n (rst_n),
    .we0   (capture),
    .a0    (rd_q),
    .d0    (cp_bus_i),
    .c0    (cp_carry),
    .we1   (wr_en),
    .a1    (wr_addr),
    .d1    (wr_data),
    .ra0   (cmd_rs),
    .rd0   (rs_data),
    .ra1   (dbg_addr),
    .rd1   (dbg_data),
    .carry (rsp_carry)
  );

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    cp_opcode = '0;
    cp_imm    = '0;
    cp_bus_o  = '0;
    cp_bus_oe = 1'b0;
    cp_oe_n   = 1'b1;
    capture   = 1'b0;
    abort     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        cp_opcode = OP_ADDI;
        cp_imm    = imm_q;
        if (cp_req == REQ_OPERAND) state_d = S_SERVE;
      end
      S_SERVE: begin
        cp_opcode = OP_ADDI;
        cp_imm    = imm_q;
        cp_bus_oe = 1'b1;
        cp_bus_o  = opnd_q;
        if (cp_req == REQ_VALUE) state_d = S_RESULT;
      end
      S_RESULT: begin
        // Zero opcode on done so the coprocessor does not relaunch.
        cp_opcode = cp_done ? 4'd0 : OP_ADDI;
        cp_imm    = imm_q;
        cp_oe_n   = 1'b0;
        if (cp_done) begin
          capture = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_q != S_IDLE && !capture && wd_q == TIMEOUT) begin
      abort   = 1'b1;
      state_d = S_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_d != state_q) wd_q <= '0;
      else if (state_q != S_IDLE) wd_q <= wd_q + 5'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      imm_q  <= '0;
      opnd_q <= '0;
      rd_q   <= '0;
    end else if (cmd_valid && cmd_ready) begin
      imm_q  <= cmd_imm;
      opnd_q <= rs_data;
      rd_q   <= cmd_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= capture || abort;
      if (capture) begin
        rsp_data <= cp_bus_i;
        rsp_err  <= 1'b0;
      end else if (abort) begin
        rsp_data <= '0;
        rsp_err  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cp_bus_host.sv
// Scoreboard bench for cp_bus_host with a cycle model of the
// shared-bus ALU coprocessor.
module tb_cp_bus_host;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_imm = '0;
  logic [2:0] cmd_rs = '0;
  logic [2:0] cmd_rd = '0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_carry;
  logic       rsp_err;
  logic       wr_en = 1'b0;
  logic [2:0] wr_addr = '0;
  logic [3:0] wr_data = '0;
  logic [2:0] dbg_addr = '0;
  logic [3:0] dbg_data;
  logic [3:0] cp_opcode;
  logic [3:0] cp_imm;
  logic [3:0] cp_req;
  logic [3:0] cp_bus_o;
  logic       cp_bus_oe;
  logic [3:0] cp_bus_i;
  logic       cp_oe_n;
  logic       cp_done;
  logic       cp_carry;

  cp_bus_host dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_imm   (cmd_imm),
    .cmd_rs    (cmd_rs),
    .cmd_rd    (cmd_rd),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_carry (rsp_carry),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .dbg_addr  (dbg_addr),
    .dbg_data  (dbg_data),
    .cp_opcode (cp_opcode),
    .cp_imm    (cp_imm),
    .cp_req    (cp_req),
    .cp_bus_o  (cp_bus_o),
    .cp_bus_oe (cp_bus_oe),
    .cp_bus_i  (cp_bus_i),
    .cp_oe_n   (cp_oe_n),
    .cp_done   (cp_done),
    .cp_carry  (cp_carry)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Coprocessor model: start, operand request, value phase, done.
  logic       hang = 1'b0;
  logic [2:0] ms;
  logic [3:0] m_imm, m_opnd, m_res;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ms <= '0; cp_req <= '0; cp_done <= 1'b0; cp_carry <= 1'b0;
      m_imm <= '0; m_opnd <= '0; m_res <= '0;
    end else if (hang) begin
      cp_req <= 4'b0001;
    end else begin
      case (ms)
        3'd0, 3'd6: begin
          if (cp_opcode == 4'd1) begin
            ms <= 3'd1; m_imm <= cp_imm;
            cp_req <= 4'b0011; cp_done <= 1'b0;
          end else ms <= 3'd0;
        end
        3'd1: begin ms <= 3'd2; cp_req <= 4'b0001; end
        3'd2: begin
          ms <= 3'd3;
          m_opnd <= cp_bus_oe ? cp_bus_o : 4'h0;
        end
        3'd3: ms <= 3'd4;
        3'd4: ms <= 3'd5;
        3'd5: begin
          ms <= 3'd6; cp_done <= 1'b1;
          {cp_carry, m_res} <= {1'b0, m_imm} + {1'b0, m_opnd};
        end
        default: ms <= 3'd0;
      endcase
    end
  end

  assign cp_bus_i = cp_oe_n ? 4'h0 : m_res;

  typedef struct {
    logic [3:0] d;
    logic       c;
    logic       e;
    int         at;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int acc = 0;
  int oe_cnt = 0;
  logic [3:0] exp_opnd = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, want, $time);
    end
  endtask

  initial forever begin
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      if (rsp_valid) begin
        if (sb.size() == 0) chk("rsp_unexpected", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_err", rsp_err, e.e);
          chk("rsp_data", rsp_data, e.d);
          if (!e.e) chk("rsp_carry", rsp_carry, e.c);
          chk("rsp_cycle", cyc, e.at);
        end
      end
      if (!cp_oe_n && cp_done) chk("opcode_on_done", cp_opcode, 0);
      if (cp_bus_oe) begin
        oe_cnt++;
        chk("bus_operand", cp_bus_o, exp_opnd);
      end
    end
  end

  task automatic send(input logic [3:0] imm, input logic [2:0] rs,
                      input logic [2:0] rd, input logic [3:0] opnd,
                      input logic [3:0] d, input logic c,
                      input logic er, input int lat);
    int n;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_imm = imm; cmd_rs = rs; cmd_rd = rd;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      chk("accept_timeout", 0, 1);
      cmd_valid = 1'b0;
      return;
    end
    acc = cyc + 1;
    e.d = d; e.c = c; e.e = er; e.at = acc + lat;
    sb.push_back(e);
    exp_opnd = opnd;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("rsp_timeout", 0, 1);
      sb.delete();
    end
    @(negedge clk);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [3:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wr_at(input int edge_n, input logic [2:0] a,
                       input logic [3:0] d);
    while (cyc < edge_n - 1) @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd_chk(input string nm, input logic [2:0] a,
                        input logic [3:0] want);
    dbg_addr = a;
    #1;
    chk(nm, dbg_data, want);
  endtask

  initial begin
    #3;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_cp_oe_n", cp_oe_n, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_data", rsp_data, 0);
    chk("rst_rsp_carry", rsp_carry, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cp_opcode", cp_opcode, 0);
    chk("rst_cp_imm", cp_imm, 0);
    chk("rst_cp_bus_oe", cp_bus_oe, 0);
    chk("rst_cp_bus_o", cp_bus_o, 0);
    rd_chk("rst_reg0", 3'd0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    reg_wr(3'd2, 4'd7);
    oe_cnt = 0;
    send(4'd5, 3'd2, 3'd4, 4'd7, 4'd12, 1'b0, 1'b0, 7);
    wait_rsp();
    chk("basic_oe_cycles", oe_cnt, 1);
    rd_chk("basic_reg4", 3'd4, 4'd12);

    reg_wr(3'd1, 4'd9);
    oe_cnt = 0;
    send(4'd9, 3'd1, 3'd1, 4'd9, 4'd2, 1'b1, 1'b0, 7);
    wait_rsp();
    chk("carry_oe_cycles", oe_cnt, 1);
    chk("carry_bus_oe_idle", cp_bus_oe, 0);
    rd_chk("carry_reg1", 3'd1, 4'd2);

    hang = 1'b1;
    oe_cnt = 0;
    send(4'd3, 3'd2, 3'd5, 4'd7, 4'd0, 1'b0, 1'b1, 32);
    wait_rsp();
    hang = 1'b0;
    chk("tmo_opcode", cp_opcode, 0);
    chk("tmo_oe_cycles", oe_cnt, 0);
    rd_chk("tmo_reg5", 3'd5, 4'd0);
    rd_chk("tmo_reg2", 3'd2, 4'd7);

    send(4'd3, 3'd4, 3'd6, 4'd12, 4'd15, 1'b0, 1'b0, 7);
    send(4'd1, 3'd6, 3'd7, 4'd15, 4'd0, 1'b1, 1'b0, 7);
    wait_rsp();
    rd_chk("b2b_reg6", 3'd6, 4'd15);
    rd_chk("b2b_reg7", 3'd7, 4'd0);

    send(4'd2, 3'd2, 3'd3, 4'd7, 4'd9, 1'b0, 1'b0, 7);
    wr_at(acc + 7, 3'd3, 4'hF);
    wait_rsp();
    rd_chk("collide_reg3", 3'd3, 4'd9);

    send(4'd0, 3'd2, 3'd0, 4'd7, 4'd7, 1'b0, 1'b0, 7);
    wr_at(acc + 2, 3'd2, 4'd1);
    wr_at(acc + 7, 3'd5, 4'hA);
    wait_rsp();
    rd_chk("split_reg0", 3'd0, 4'd7);
    rd_chk("split_reg5", 3'd5, 4'hA);
    rd_chk("split_reg2", 3'd2, 4'd1);

    send(4'd1, 3'd1, 3'd1, 4'd2, 4'd3, 1'b0, 1'b0, 7);
    begin
      int n = 0;
      while (!cp_bus_oe && n < 20) begin
        @(negedge clk);
        n++;
      end
    end
    chk("serve_reached", cp_bus_oe, 1);
    #1;
    rst_n = 1'b0;
    #1;
    sb.delete();
    chk("arst_bus_oe", cp_bus_oe, 0);
    chk("arst_cp_oe_n", cp_oe_n, 1);
    chk("arst_cmd_ready", cmd_ready, 1);
    chk("arst_opcode", cp_opcode, 0);
    for (int i = 0; i < 8; i++) rd_chk("arst_reg", 3'(i), 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    send(4'd4, 3'd0, 3'd2, 4'd0, 4'd4, 1'b0, 1'b0, 7);
    wait_rsp();
    rd_chk("post_rst_reg2", 3'd2, 4'd4);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
